hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns all writes to the HI and LO special registers.
- Executes MULT/MULTU/DIV/DIVU over 32 iterations, and MTHI/MTLO in a single cycle.
- Drives the load inputs of the two HI/LO holding registers and raises a pipeline stall while busy.
- Sits in EX beside the ALU; the HI/LO registers remain separate instances.

Parameters:
- ITER, 32, iteration count; equals the operand width.

Ports:
- Clk  in  1  system clock, rising edge.
- Clr_n  in  1  reset, synchronous, active-low.
- Start  in  1  issue the operation on Op this cycle.
- Op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved.
- A  in  32  rs operand (multiplicand, dividend, or MTHI/MTLO data).
- B  in  32  rt operand (multiplier or divisor).
- RdReq  in  1  MFHI/MFLO in decode this cycle.
- Busy  out  1  iterative operation in flight.
- Stall  out  1  hold IF/ID; equals Busy & (Start | RdReq).
- Done  out  1  one-cycle pulse during the result write cycle.
- DivByZero  out  1  pulse with Done when a divide had B==0.
- HI_in  out  32  data to the HI register.
- LO_in  out  32  data to the LO register.
- HI_Ld  out  1  HI register load enable.
- LO_Ld  out  1  LO register load enable.

Behaviour:
- Reset: Clr_n low at a rising edge forces state IDLE and clears all internal registers.
  - While in IDLE after reset, every output is 0.
  - Reset mid-operation abandons the operation; no HI/LO load occurs.
- States: IDLE, MUL, DIV, FIX, WRITE.
- IDLE, Start=1 with Op 0-3 (edge E0):
  - Latch operand magnitudes and a signed flag; signed ops take two's-complement absolute values.
  - Clear the 64-bit accumulator and iteration counter; go to MUL or DIV.
- MUL: one shift-add step per cycle (accumulator 64 bits, 33-bit add). After ITER steps, go to FIX.
- DIV: one restoring step per cycle (33-bit trial subtract; quotient bit = no borrow). After ITER steps, go to FIX.
- FIX: one cycle.
  - Negate the product if the operand signs differ (signed MULT only).
  - Quotient takes sign A^B; remainder takes the sign of A (signed DIV only).
- WRITE: one cycle.
  - HI_Ld=LO_Ld=1 and Done=1.
  - HI_in = product[63:32] or remainder; LO_in = product[31:0] or quotient.
  - Next state IDLE.
- Latency: HI/LO hold the result at edge E34. Busy is high for the 34 cycles after E0, including WRITE.
- Divide by zero: skip sign fix; HI_in=A, LO_in=0xFFFFFFFF, DivByZero=1 in WRITE.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0; this falls out of the magnitude path with no special case.
- MTHI/MTLO in IDLE: combinational write in the same cycle.
  - HI_Ld (or LO_Ld)=1 with HI_in (or LO_in)=A.
  - No state change, no Done.
- Busy behaviour:
  - Start while Busy is ignored and Stall=1; the pipeline re-presents the op after Busy drops.
  - RdReq while Busy gives Stall=1.
  - The cycle in which Busy falls has Stall=0.
- Reserved Op with Start: ignored, no output activity.
- Outside WRITE and MTHI/MTLO cycles: HI_Ld=LO_Ld=0 and HI_in=LO_in=0.

Decomposition:
- Shared package hilo_pkg holds:
  - Op encodings OP_MULT..OP_MTLO.
  - State encoding ST_IDLE..ST_WRITE.
  - ITER default.
- One sub-module, muldiv_step: combinational single iteration (shift-add or restore-subtract selected by a mode bit) on {acc[63:0], operand[31:0]}.
- The controller holds the FSM, counter, sign fix and HI/LO load generation.

Test Plan:
- MULT A=0xFFFFFFFD, B=5 -> at E34 HI=0xFFFFFFFF, LO=0xFFFFFFF1; Done one cycle; Busy 34 cycles.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=100, B=0 -> HI=0x00000064, LO=0xFFFFFFFF, DivByZero pulse with Done.
- MTHI A=0x12345678 in IDLE -> HI_Ld same cycle with HI_in=0x12345678.
- MTLO or RdReq during MUL -> Stall=1, LO_Ld=0.
- Clr_n low at iteration 10 -> IDLE next edge, Busy=0, no HI_Ld/LO_Ld.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// Op codes, FSM states, default iteration count and a conditional-negate helper.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int ITER_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIX   = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  function automatic logic [31:0] cneg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: right-shift shift-add multiply or left-shift restoring divide.
// acc holds {partial, shift register}; a single 33-bit adder serves both modes.
module muldiv_step (
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  input  logic        div_i,
  output logic [63:0] acc_o
);

  logic [32:0] add_a;
  logic [32:0] add_b;
  logic [32:0] res;
  logic        cout;

  // Divide computes partial - divisor as partial + ~divisor + 1; carry out means no borrow.
  assign add_a = div_i ? acc_i[63:31] : {1'b0, acc_i[63:32]};
  assign add_b = div_i ? ~{1'b0, opnd_i} : {1'b0, opnd_i};
  assign {cout, res} = {1'b0, add_a} + {1'b0, add_b} + {33'd0, div_i};

  always_comb begin
    acc_o = acc_i;
    if (div_i) begin
      if (cout) acc_o = {res[31:0], acc_i[30:0], 1'b1};
      else      acc_o = {acc_i[62:0], 1'b0};
    end else begin
      if (acc_i[0]) acc_o = {res, acc_i[31:1]};
      else          acc_o = {1'b0, acc_i[63:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write owner: 32-step iterative MULT/MULTU/DIV/DIVU plus single-cycle MTHI/MTLO.
// Operands are processed as magnitudes; signs are restored in one FIX cycle before WRITE.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic        Clk,
  input  logic        Clr_n,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        RdReq,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] HI_in,
  output logic [31:0] LO_in,
  output logic        HI_Ld,
  output logic        LO_Ld
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   opnd_q, opnd_d;
  logic          neg_res_q, neg_res_d;
  logic          neg_a_q, neg_a_d;
  logic          is_div_q, is_div_d;
  logic          divz_q, divz_d;

  logic [63:0]   step_acc;
  logic          sgn_op;
  logic          div_op;
  logic          a_neg;
  logic          b_neg;

  muldiv_step u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (state_q == ST_DIV),
    .acc_o  (step_acc)
  );

  assign sgn_op = (Op == OP_MULT) || (Op == OP_DIV);
  assign div_op = (Op == OP_DIV) || (Op == OP_DIVU);
  assign a_neg  = sgn_op & A[31];
  assign b_neg  = sgn_op & B[31];

  always_ff @(posedge Clk) begin
    if (!Clr_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      is_div_q  <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      is_div_q  <= is_div_d;
      divz_q    <= divz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    is_div_d  = is_div_q;
    divz_d    = divz_q;
    Done      = 1'b0;
    DivByZero = 1'b0;
    HI_in     = '0;
    LO_in     = '0;
    HI_Ld     = 1'b0;
    LO_Ld     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          case (Op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              // Low half doubles as multiplier / dividend shift register.
              acc_d     = {32'd0, cneg(A, a_neg)};
              opnd_d    = cneg(B, b_neg);
              neg_res_d = a_neg ^ b_neg;
              neg_a_d   = a_neg;
              is_div_d  = div_op;
              divz_d    = div_op && (B == 32'd0);
              cnt_d     = '0;
              state_d   = div_op ? ST_DIV : ST_MUL;
            end
            OP_MTHI: begin
              HI_Ld = 1'b1;
              HI_in = A;
            end
            OP_MTLO: begin
              LO_Ld = 1'b1;
              LO_in = A;
            end
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (!is_div_q) begin
          acc_d = neg_res_q ? (~acc_q + 64'd1) : acc_q;
        end else if (divz_q) begin
          // A zero divisor leaves |A| in the remainder half; re-signing it recovers A.
          acc_d = {cneg(acc_q[63:32], neg_a_q), 32'hFFFF_FFFF};
        end else begin
          acc_d = {cneg(acc_q[63:32], neg_a_q), cneg(acc_q[31:0], neg_res_q)};
        end
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        HI_Ld     = 1'b1;
        LO_Ld     = 1'b1;
        HI_in     = acc_q[63:32];
        LO_in     = acc_q[31:0];
        Done      = 1'b1;
        DivByZero = divz_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Busy  = (state_q != ST_IDLE);
  assign Stall = Busy & (Start | RdReq);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Table-driven bench with a result scoreboard and a bench-side HI/LO register model.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic        Clk;
  logic        Clr_n;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        RdReq;
  logic        Busy;
  logic        Stall;
  logic        Done;
  logic        DivByZero;
  logic [31:0] HI_in;
  logic [31:0] LO_in;
  logic        HI_Ld;
  logic        LO_Ld;

  hilo_muldiv_ctrl dut (
    .Clk       (Clk),
    .Clr_n     (Clr_n),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .RdReq     (RdReq),
    .Busy      (Busy),
    .Stall     (Stall),
    .Done      (Done),
    .DivByZero (DivByZero),
    .HI_in     (HI_in),
    .LO_in     (LO_in),
    .HI_Ld     (HI_Ld),
    .LO_Ld     (LO_Ld)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  localparam int NV = 11;
  vec_t  vt[NV];
  exp_t  sbq[$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic [31:0] hi_reg, lo_reg;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (HI_Ld) hi_reg <= HI_in;
    if (LO_Ld) lo_reg <= LO_in;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {Busy, Stall, Done, DivByZero, HI_Ld, LO_Ld};
  endfunction

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = '0; lo = '0; dz = 1'b0;
    case (op)
      OP_MULT:  begin p = sa * sb; {hi, lo} = p; end
      OP_MULTU: begin p = ua * ub; {hi, lo} = p; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (op == OP_DIV) begin
          q = sa / sb; r = sa % sb;
          hi = r[31:0]; lo = q[31:0];
        end else begin
          uq = ua / ub; ur = ua % ub;
          hi = ur[31:0]; lo = uq[31:0];
        end
      end
    endcase
  endfunction

  // poke=1 presents MTLO and then RdReq partway through the operation.
  task automatic run_iter(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input int poke);
    exp_t e;
    int busy_n, done_n, stray;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    e.hi = ehi; e.lo = elo; e.dz = edz;
    sbq.push_back(e);
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
    busy_n = 0; done_n = 0; stray = 0;
    for (int c = 0; c < 100 && Busy; c++) begin
      busy_n++;
      if (poke == 1 && c == 5) begin
        Start = 1'b1; Op = OP_MTLO; A = 32'hDEAD_BEEF;
        #1;
        chk("stall_on_start", 64'(Stall), 64'd1);
        chk("no_lo_ld_busy", 64'(LO_Ld), 64'd0);
      end
      if (poke == 1 && c == 6) begin
        Start = 1'b0; Op = 3'd0; A = 32'd0; RdReq = 1'b1;
        #1;
        chk("stall_on_rdreq", 64'(Stall), 64'd1);
      end
      if (poke == 1 && c == 7) RdReq = 1'b0;
      if (Done) begin
        done_n++;
        chk("done_cycle", 64'(busy_n), 64'd34);
        chk("ld_both", 64'({HI_Ld, LO_Ld}), 64'd3);
        if (sbq.size() == 0) begin
          chk("sb_underflow", 64'(sbq.size()), 64'd1);
        end else begin
          e = sbq.pop_front();
          chk("hi_in", 64'(HI_in), 64'(e.hi));
          chk("lo_in", 64'(LO_in), 64'(e.lo));
          chk("divbyzero", 64'(DivByZero), 64'(e.dz));
        end
      end else if (HI_Ld || LO_Ld || DivByZero) begin
        stray++;
      end
      @(negedge Clk);
    end
    chk("busy_cycles", 64'(busy_n), 64'd34);
    chk("done_pulses", 64'(done_n), 64'd1);
    chk("stray_loads", 64'(stray), 64'd0);
    chk("hi_reg", 64'(hi_reg), 64'(e.hi));
    chk("lo_reg", 64'(lo_reg), 64'(e.lo));
    RdReq = 1'b1;
    #1;
    chk("stall_after_busy", 64'(Stall), 64'd0);
    RdReq = 1'b0;
  endtask

  initial begin
    logic [31:0] mh, ml;
    logic        md;
    int          loads;

    vt[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vt[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vt[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vt[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vt[4] = '{OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vt[5] = '{OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0};
    vt[6] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 1'b0};
    vt[7] = '{OP_DIV,   32'd100,       32'hFFFF_FFF9, 32'd0, 32'd0, 1'b0};
    vt[8] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd7,         32'd0, 32'd0, 1'b0};
    vt[9] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'd0, 32'd0, 1'b0};
    vt[10] = '{OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0};
    for (int i = 5; i < NV; i++) begin
      model(vt[i].op, vt[i].a, vt[i].b, mh, ml, md);
      vt[i].hi = mh; vt[i].lo = ml; vt[i].dz = md;
    end

    Clr_n = 1'b0; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0; RdReq = 1'b0;
    repeat (3) @(negedge Clk);
    Clr_n = 1'b1;
    @(negedge Clk);
    chk("reset_flags", 64'(flags()), 64'd0);
    chk("reset_data", {HI_in, LO_in}, 64'd0);

    // MTHI / MTLO write combinationally in the issuing cycle.
    Start = 1'b1; Op = OP_MTHI; A = 32'h1234_5678;
    #1;
    chk("mthi_flags", 64'(flags()), 64'b000010);
    chk("mthi_data", {HI_in, LO_in}, {32'h1234_5678, 32'd0});
    @(negedge Clk);
    Op = OP_MTLO; A = 32'hCAFE_F00D;
    #1;
    chk("mthi_hi_reg", 64'(hi_reg), 64'h1234_5678);
    chk("mtlo_flags", 64'(flags()), 64'b000001);
    chk("mtlo_data", {HI_in, LO_in}, {32'd0, 32'hCAFE_F00D});
    @(negedge Clk);
    Op = 3'd6; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    #1;
    chk("rsvd_flags", 64'(flags()), 64'd0);
    chk("rsvd_data", {HI_in, LO_in}, 64'd0);
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
    chk("rsvd_no_busy", 64'(Busy), 64'd0);

    for (int i = 0; i < NV; i++)
      run_iter(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].dz, 0);

    run_iter(OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1);

    // Reset mid-divide: the operation is dropped with no HI/LO load.
    @(negedge Clk);
    Start = 1'b1; Op = OP_DIV; A = 32'd1000; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (10) @(negedge Clk);
    chk("busy_before_clr", 64'(Busy), 64'd1);
    Clr_n = 1'b0;
    @(negedge Clk);
    chk("clr_flags", 64'(flags()), 64'd0);
    Clr_n = 1'b1;
    loads = 0;
    for (int c = 0; c < 40; c++) begin
      if (HI_Ld || LO_Ld || Done || Busy) loads++;
      @(negedge Clk);
    end
    chk("clr_no_activity", 64'(loads), 64'd0);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
